rice_bit_window: RTL and testbench

//  Parametrised bit-window front end for the Rice (CCSDS-121 style) decoder.

---
 rtl/rice_pkg.sv | 6 +
 rtl/rice_lzc.sv | 22 ++
 rtl/rice_bit_window.sv | 144 ++++++++++++++
 tb/tb_rice_bit_window.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_pkg.sv
// rice_pkg: shared state encoding and default sizing for the Rice bit-window front end
package rice_pkg;
    typedef enum logic [1:0] {IDLE, FS, REM} state_e;
    localparam int BUF_W_DEF = 64;
    localparam int CNT_W = $clog2(BUF_W_DEF + 1);
endpackage

// File: rtl/rice_lzc.sv
// rice_lzc: leading-zero counter over the valid (top cnt_i) bits of a left-aligned vector
//   vec_i      : left-aligned bit buffer
//   cnt_i      : number of valid bits counted from the MSB
//   lz_o       : zeros before the first '1' (W when none)
//   all_zero_o : no '1' among the valid bits
module rice_lzc #(
    parameter int W = 64
) (
    input  logic [W-1:0]           vec_i,
    input  logic [$clog2(W+1)-1:0] cnt_i,
    output logic [$clog2(W+1)-1:0] lz_o,
    output logic                   all_zero_o
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] m;
    always_comb begin
        m = vec_i & ~({W{1'b1}} >> cnt_i);
        lz_o = CW'(W);
        for (int i = 0; i < W; i++) if (m[i]) lz_o = CW'(W - 1 - i);
    end
    assign all_zero_o = ~|m;
endmodule

// File: rtl/rice_bit_window.sv
// rice_bit_window: bit buffer that splits Rice blocks into FS lengths and k-bit remainders
//   in_*      : packed input words, MSB first, valid/ready
//   blk_start_i/k_i/j_i : start a block of j samples with remainder width k
//   flush_i   : drop buffered bits, clear error, return to IDLE
//   sym_*     : decoded symbols (phase 0 = FS length, 1 = remainder), valid/ready
//   fs_done_o/rem_done_o/blk_done_o : one-cycle completion pulses
//   err_o     : sticky, FS run overflowed a full buffer
//   bits_avail_o : valid bits held in the buffer
import rice_pkg::*;
module rice_bit_window #(
    parameter int IN_W  = 32,
    parameter int BUF_W = 64,
    parameter int KW    = 6,
    parameter int JW    = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [IN_W-1:0]            in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       blk_start_i,
    input  logic [KW-1:0]              k_i,
    input  logic [JW-1:0]              j_i,
    input  logic                       flush_i,
    output logic [BUF_W-1:0]           sym_data_o,
    output logic                       sym_phase_o,
    output logic                       sym_valid_o,
    input  logic                       sym_ready_i,
    output logic                       fs_done_o,
    output logic                       rem_done_o,
    output logic                       blk_done_o,
    output logic                       err_o,
    output logic [$clog2(BUF_W+1)-1:0] bits_avail_o
);
    localparam int CW = $clog2(BUF_W + 1);
    state_e st_q, st_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d, lz, n, cnt_c, kc;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] fcnt_q, fcnt_d, rcnt_q, rcnt_d;
    logic err_q, err_d, fs_done_q, fs_done_d, rem_done_q, rem_done_d, blk_done_q, blk_done_d;
    logic all_zero, fs_ok, rem_ok, fire, acc, err_c;
    rice_lzc #(.W(BUF_W)) u_lzc (
        .vec_i     (buf_q),
        .cnt_i     (cnt_q),
        .lz_o      (lz),
        .all_zero_o(all_zero)
    );
    assign kc           = CW'(k_q);
    assign fs_ok        = st_q == FS && lz < cnt_q;
    assign rem_ok       = st_q == REM && cnt_q >= kc;
    assign sym_valid_o  = fs_ok | rem_ok;
    assign sym_phase_o  = st_q == REM;
    assign sym_data_o   = fs_ok ? BUF_W'(lz) : rem_ok ? buf_q >> (CW'(BUF_W) - kc) : '0;
    assign fire         = sym_valid_o & sym_ready_i;
    assign n            = !fire ? '0 : fs_ok ? lz + 1'b1 : kc;
    assign cnt_c        = cnt_q - n;
    assign in_ready_o   = cnt_q <= CW'(BUF_W - IN_W);
    assign acc          = in_valid_i & in_ready_o;
    // A full buffer with no '1' can never complete an FS code, so it is an error.
    assign err_c        = st_q == FS && cnt_q == CW'(BUF_W) && all_zero;
    assign fs_done_o    = fs_done_q;
    assign rem_done_o   = rem_done_q;
    assign blk_done_o   = blk_done_q;
    assign err_o        = err_q;
    assign bits_avail_o = cnt_q;
    always_comb begin
        st_d       = st_q;
        k_d        = k_q;
        fcnt_d     = fcnt_q;
        rcnt_d     = rcnt_q;
        err_d      = err_q;
        fs_done_d  = 1'b0;
        rem_done_d = 1'b0;
        blk_done_d = 1'b0;
        // New word lands directly behind the bits that survive this cycle's consume.
        buf_d      = (buf_q << n) | (acc ? {in_data_i, {(BUF_W-IN_W){1'b0}}} >> cnt_c : '0);
        cnt_d      = cnt_c + (acc ? CW'(IN_W) : '0);
        if (st_q == IDLE && blk_start_i) begin
            if (j_i != '0) begin
                st_d   = FS;
                k_d    = k_i;
                fcnt_d = j_i;
                rcnt_d = j_i;
            end else blk_done_d = 1'b1;
        end
        if (fire && fs_ok) begin
            fcnt_d = fcnt_q - 1'b1;
            if (fcnt_q == JW'(1)) begin
                fs_done_d  = 1'b1;
                blk_done_d = k_q == '0;
                st_d       = k_q == '0 ? IDLE : REM;
            end
        end
        if (fire && rem_ok) begin
            rcnt_d = rcnt_q - 1'b1;
            if (rcnt_q == JW'(1)) begin
                rem_done_d = 1'b1;
                blk_done_d = 1'b1;
                st_d       = IDLE;
            end
        end
        if (err_c) begin
            err_d = 1'b1;
            buf_d = '0;
            cnt_d = '0;
            st_d  = IDLE;
        end
        if (flush_i) begin
            err_d      = 1'b0;
            buf_d      = '0;
            cnt_d      = '0;
            st_d       = IDLE;
            fs_done_d  = 1'b0;
            rem_done_d = 1'b0;
            blk_done_d = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q       <= IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            fcnt_q     <= '0;
            rcnt_q     <= '0;
            err_q      <= 1'b0;
            fs_done_q  <= 1'b0;
            rem_done_q <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            fcnt_q     <= fcnt_d;
            rcnt_q     <= rcnt_d;
            err_q      <= err_d;
            fs_done_q  <= fs_done_d;
            rem_done_q <= rem_done_d;
            blk_done_q <= blk_done_d;
        end
    end
endmodule

// File: tb/tb_rice_bit_window.sv
// tb_rice_bit_window: directed scenario tests for rice_bit_window
module tb_rice_bit_window;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        blk_start = 1'b0;
    logic [5:0]  k = '0;
    logic [5:0]  j = '0;
    logic        flush = 1'b0;
    logic [63:0] sym_data;
    logic        sym_phase, sym_valid;
    logic        sym_ready = 1'b0;
    logic        fs_done, rem_done, blk_done, err;
    logic [6:0]  bits_avail;
    int n_chk = 0;
    int n_fail = 0;
    rice_bit_window dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .blk_start_i (blk_start),
        .k_i         (k),
        .j_i         (j),
        .flush_i     (flush),
        .sym_data_o  (sym_data),
        .sym_phase_o (sym_phase),
        .sym_valid_o (sym_valid),
        .sym_ready_i (sym_ready),
        .fs_done_o   (fs_done),
        .rem_done_o  (rem_done),
        .blk_done_o  (blk_done),
        .err_o       (err),
        .bits_avail_o(bits_avail)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [31:0] w);
        int t = 0;
        in_data = w;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_timeout got in_ready=%b need 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask
    task automatic pop(output logic [63:0] d, output logic ph);
        int t = 0;
        while (!sym_valid && t < 50) begin
            step();
            t++;
        end
        n_chk++;
        if (sym_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_timeout got sym_valid=%b need 1", sym_valid);
        end
        d = sym_data;
        ph = sym_phase;
        sym_ready = 1'b1;
        step();
        sym_ready = 1'b0;
    endtask
    task automatic start(input logic [5:0] kk, input logic [5:0] jj);
        k = kk;
        j = jj;
        blk_start = 1'b1;
        step();
        blk_start = 1'b0;
    endtask
    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_chk++;
        if ({in_ready, sym_valid, sym_phase, fs_done, rem_done, blk_done, err} !== 7'b1000000 || sym_data !== 64'd0 || bits_avail !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b v=%b ph=%b d=%h fd=%b rd=%b bd=%b err=%b bits=%0d", in_ready, sym_valid, sym_phase, sym_data, fs_done, rem_done, blk_done, err, bits_avail);
        end
    endtask
    task automatic test_basic();
        logic [63:0] d;
        logic ph;
        push(32'h5A00_0000);
        n_chk++;
        if (bits_avail !== 7'd32) begin n_fail++; $display("FAIL t1_bits_after_push got %0d need 32", bits_avail); end
        start(6'd2, 6'd2);
        pop(d, ph);
        n_chk++;
        if (d !== 64'd1 || ph !== 1'b0 || fs_done !== 1'b0) begin n_fail++; $display("FAIL t1_fs0 got d=%0d ph=%b fd=%b need 1 0 0", d, ph, fs_done); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd1 || ph !== 1'b0 || fs_done !== 1'b1 || blk_done !== 1'b0) begin n_fail++; $display("FAIL t1_fs1 got d=%0d ph=%b fd=%b bd=%b need 1 0 1 0", d, ph, fs_done, blk_done); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd2 || ph !== 1'b1 || rem_done !== 1'b0) begin n_fail++; $display("FAIL t1_rem0 got d=%0d ph=%b rd=%b need 2 1 0", d, ph, rem_done); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd2 || ph !== 1'b1 || rem_done !== 1'b1 || blk_done !== 1'b1 || bits_avail !== 7'd24) begin n_fail++; $display("FAIL t1_rem1 got d=%0d ph=%b rd=%b bd=%b bits=%0d need 2 1 1 1 24", d, ph, rem_done, blk_done, bits_avail); end
        step();
        n_chk++;
        if (blk_done !== 1'b0 || sym_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_end got bd=%b v=%b need 0 0", blk_done, sym_valid); end
    endtask
    task automatic test_zero_j();
        do_flush();
        start(6'd3, 6'd0);
        n_chk++;
        if (blk_done !== 1'b1 || sym_valid !== 1'b0) begin n_fail++; $display("FAIL j0_done got bd=%b v=%b need 1 0", blk_done, sym_valid); end
        step();
        n_chk++;
        if (blk_done !== 1'b0) begin n_fail++; $display("FAIL j0_pulse got bd=%b need 0", blk_done); end
    endtask
    task automatic test_k0();
        logic [63:0] d;
        logic ph;
        do_flush();
        push(32'hB000_0000);
        start(6'd0, 6'd3);
        pop(d, ph);
        n_chk++;
        if (d !== 64'd0 || ph !== 1'b0) begin n_fail++; $display("FAIL t2_fs0 got d=%0d ph=%b need 0 0", d, ph); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd1 || fs_done !== 1'b0) begin n_fail++; $display("FAIL t2_fs1 got d=%0d fd=%b need 1 0", d, fs_done); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd0 || fs_done !== 1'b1 || blk_done !== 1'b1 || rem_done !== 1'b0 || sym_valid !== 1'b0 || bits_avail !== 7'd28) begin
            n_fail++;
            $display("FAIL t2_fs2 got d=%0d fd=%b bd=%b rd=%b v=%b bits=%0d need 0 1 1 0 0 28", d, fs_done, blk_done, rem_done, sym_valid, bits_avail);
        end
    endtask
    task automatic test_long_fs();
        logic [63:0] d;
        logic ph;
        do_flush();
        start(6'd0, 6'd1);
        push(32'h0000_0000);
        step();
        n_chk++;
        if (sym_valid !== 1'b0 || bits_avail !== 7'd32) begin n_fail++; $display("FAIL t3_wait got v=%b bits=%0d need 0 32", sym_valid, bits_avail); end
        push(32'h8000_0000);
        n_chk++;
        if (sym_valid !== 1'b1 || sym_data !== 64'd32) begin n_fail++; $display("FAIL t3_latency got v=%b d=%0d need 1 32", sym_valid, sym_data); end
        pop(d, ph);
        n_chk++;
        if (d !== 64'd32 || blk_done !== 1'b1 || bits_avail !== 7'd31) begin n_fail++; $display("FAIL t3_fs got d=%0d bd=%b bits=%0d need 32 1 31", d, blk_done, bits_avail); end
    endtask
    task automatic test_error();
        do_flush();
        start(6'd0, 6'd1);
        push(32'h0);
        push(32'h0);
        n_chk++;
        if (bits_avail !== 7'd64 || in_ready !== 1'b0) begin n_fail++; $display("FAIL t4_full got bits=%0d rdy=%b need 64 0", bits_avail, in_ready); end
        step();
        n_chk++;
        if (err !== 1'b1 || bits_avail !== 7'd0 || sym_valid !== 1'b0 || fs_done !== 1'b0 || blk_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_err got err=%b bits=%0d v=%b fd=%b bd=%b need 1 0 0 0 0", err, bits_avail, sym_valid, fs_done, blk_done);
        end
        push(32'h4000_0000);
        n_chk++;
        if (err !== 1'b1 || sym_valid !== 1'b0) begin n_fail++; $display("FAIL t4_sticky got err=%b v=%b need 1 0", err, sym_valid); end
        do_flush();
        n_chk++;
        if (err !== 1'b0 || in_ready !== 1'b1 || bits_avail !== 7'd0) begin n_fail++; $display("FAIL t4_flush got err=%b rdy=%b bits=%0d need 0 1 0", err, in_ready, bits_avail); end
    endtask
    task automatic test_back_pressure();
        logic [63:0] d;
        logic ph;
        do_flush();
        start(6'd2, 6'd2);
        in_data = 32'h5A00_0000;
        in_valid = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if (sym_valid !== 1'b1 || sym_data !== 64'd1) begin n_fail++; $display("FAIL t5_stable%0d got v=%b d=%0d need 1 1", c, sym_valid, sym_data); end
            step();
        end
        n_chk++;
        if (in_ready !== 1'b0 || bits_avail !== 7'd64) begin n_fail++; $display("FAIL t5_ready got rdy=%b bits=%0d need 0 64", in_ready, bits_avail); end
        in_valid = 1'b0;
        pop(d, ph);
        pop(d, ph);
        n_chk++;
        if (d !== 64'd1 || fs_done !== 1'b1) begin n_fail++; $display("FAIL t5_fs got d=%0d fd=%b need 1 1", d, fs_done); end
        pop(d, ph);
        pop(d, ph);
        n_chk++;
        if (d !== 64'd2 || ph !== 1'b1 || blk_done !== 1'b1 || bits_avail !== 7'd56 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_rem got d=%0d ph=%b bd=%b bits=%0d rdy=%b need 2 1 1 56 0", d, ph, blk_done, bits_avail, in_ready);
        end
    endtask
    task automatic test_reset_mid_block();
        logic [63:0] d;
        logic ph;
        do_flush();
        push(32'h0000_0100);
        push(32'hFFFF_FFFF);
        start(6'd2, 6'd1);
        pop(d, ph);
        n_chk++;
        if (d !== 64'd23 || sym_phase !== 1'b1 || bits_avail !== 7'd40 || sym_valid !== 1'b1 || sym_data !== 64'd0) begin
            n_fail++;
            $display("FAIL t6_setup got d=%0d ph=%b bits=%0d v=%b sd=%0d need 23 1 40 1 0", d, sym_phase, bits_avail, sym_valid, sym_data);
        end
        sym_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sym_ready = 1'b0;
        n_chk++;
        if ({in_ready, sym_valid, sym_phase, fs_done, rem_done, blk_done, err} !== 7'b1000000 || sym_data !== 64'd0 || bits_avail !== 7'd0) begin
            n_fail++;
            $display("FAIL t6_reset got rdy=%b v=%b ph=%b d=%h fd=%b rd=%b bd=%b err=%b bits=%0d", in_ready, sym_valid, sym_phase, sym_data, fs_done, rem_done, blk_done, err, bits_avail);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_zero_j();
        test_k0();
        test_long_fs();
        test_error();
        test_back_pressure();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
